// File: rtl/muldiv_unit_if.sv
// Request/result interface of the multiply/divide unit.
// The master side issues MUL/DIV/MTHI/MTLO requests and the slave side
// returns busy/done/dbz and the architectural HI/LO pair.
interface muldiv_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             flush;
    logic             busy;
    logic             done;
    logic             dbz;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, flush,
        input  busy, done, dbz, hi, lo
    );

    modport slave (
        input  start, op, a, b, flush,
        output busy, done, dbz, hi, lo
    );
endinterface

// File: rtl/muldiv_unit.sv
// Sequential multiply/divide unit holding the MIPS HI/LO register pair.
// MULT/MULTU use shift-add and DIV/DIVU use restoring division on operand
// magnitudes, one bit per cycle, with a final sign-fix cycle. MTHI/MTLO
// write HI/LO directly at the start edge.
// Optional feature macro: MULDIV_FAST_MUL_EN -- MULT/MULTU compute the full
// product in the start cycle and go straight to the sign-fix cycle.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input logic          clk,
    input logic          reset,
    muldiv_unit_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t state, next_state;

    logic [WIDTH-1:0] p_hi, p_lo, mcand;
    logic [CW-1:0]    count;
    logic             is_div, neg_q, neg_r, dz;
    logic [WIDTH-1:0] hi_q, lo_q;
    logic             done_q, dbz_q;

    logic             issue, op_mul, op_div, op_mt, signed_op;
    logic [WIDTH-1:0] abs_a, abs_b;

    assign op_mul    = (bus.op[2:1] == 2'b00);
    assign op_div    = (bus.op[2:1] == 2'b01);
    assign op_mt     = (bus.op[2:1] == 2'b10);
    assign signed_op = !bus.op[0];
    // A flush in the same cycle as start cancels the request.
    assign issue     = bus.start && !bus.flush && (state == IDLE);

    assign abs_a = (signed_op && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    assign abs_b = (signed_op && bus.b[WIDTH-1]) ? -bus.b : bus.b;

    // One shift-add multiply step: add the multiplicand when the LSB of the
    // multiplier is set, then shift the {p_hi,p_lo} pair right by one.
    logic [WIDTH-1:0] mul_addend;
    logic [WIDTH:0]   mul_sum;
    assign mul_addend = p_lo[0] ? mcand : {WIDTH{1'b0}};
    assign mul_sum    = {1'b0, p_hi} + {1'b0, mul_addend};

    // One restoring divide step: shift the next dividend bit into the
    // partial remainder and subtract the divisor if it fits.
    logic [WIDTH:0]   div_shift;
    logic             div_ge;
    logic [WIDTH-1:0] div_sub;
    assign div_shift = {p_hi, p_lo[WIDTH-1]};
    assign div_ge    = (div_shift >= {1'b0, mcand});
    assign div_sub   = div_shift[WIDTH-1:0] - mcand;

    // Sign correction. Divide by zero leaves |a| as remainder, which the
    // dividend-sign fix turns back into a; the quotient is forced to ones.
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix, res_hi, res_lo;
    assign prod_fix = neg_q ? -{p_hi, p_lo} : {p_hi, p_lo};
    assign quo_fix  = dz ? {WIDTH{1'b1}} : (neg_q ? -p_lo : p_lo);
    assign rem_fix  = neg_r ? -p_hi : p_hi;
    assign res_hi   = is_div ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
    assign res_lo   = is_div ? quo_fix : prod_fix[WIDTH-1:0];

`ifdef MULDIV_FAST_MUL_EN
    logic [2*WIDTH-1:0] fast_prod;
    assign fast_prod = {{WIDTH{1'b0}}, abs_a} * {{WIDTH{1'b0}}, abs_b};
`endif

    // State register.
    // NOTE: clocked state uses non-blocking (<=) so every flop samples the
    // pre-edge values of the others, independent of block ordering.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= next_state;
    end

    // Next-state logic.
    // NOTE: next_state gets a default before the case so no path leaves it
    // unassigned, which would infer a latch.
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: begin
                if (issue && op_div) begin
                    next_state = RUN;
                end else if (issue && op_mul) begin
`ifdef MULDIV_FAST_MUL_EN
                    next_state = FIX;
`else
                    next_state = RUN;
`endif
                end
            end
            RUN: begin
                if (bus.flush)                            next_state = IDLE;
                else if (count == CW'(WIDTH - 1))         next_state = FIX;
            end
            FIX:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Operand capture and per-cycle iteration datapath.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            p_hi   <= '0;
            p_lo   <= '0;
            mcand  <= '0;
            count  <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            dz     <= 1'b0;
        end else if (state == IDLE) begin
            if (issue && (op_mul || op_div)) begin
                mcand  <= abs_b;
                p_lo   <= abs_a;
                p_hi   <= '0;
                count  <= '0;
                is_div <= op_div;
                neg_q  <= signed_op && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                neg_r  <= signed_op && bus.a[WIDTH-1];
                dz     <= op_div && (bus.b == '0);
`ifdef MULDIV_FAST_MUL_EN
                if (op_mul) {p_hi, p_lo} <= fast_prod;
`endif
            end
        end else if (state == RUN) begin
            count <= count + 1'b1;
            if (is_div) begin
                p_hi <= div_ge ? div_sub : div_shift[WIDTH-1:0];
                p_lo <= {p_lo[WIDTH-2:0], div_ge};
            end else begin
                p_hi <= mul_sum[WIDTH:1];
                p_lo <= {mul_sum[0], p_lo[WIDTH-1:1]};
            end
        end
    end

    // Architectural HI/LO, done pulse and divide-by-zero flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi_q   <= '0;
            lo_q   <= '0;
            done_q <= 1'b0;
            dbz_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (issue && op_mt) begin
                if (bus.op[0]) lo_q <= bus.a;
                else           hi_q <= bus.a;
                done_q <= 1'b1;
                dbz_q  <= 1'b0;
            end else if (state == FIX && !bus.flush) begin
                hi_q   <= res_hi;
                lo_q   <= res_lo;
                done_q <= 1'b1;
                dbz_q  <= dz;
            end
        end
    end

    assign bus.busy = (state != IDLE);
    assign bus.done = done_q;
    assign bus.dbz  = dbz_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: an arithmetic reference model with an outstanding-op
// countdown is compared against the DUT every cycle, plus directed literal
// expectations for each scenario.
module tb_muldiv_unit;
    localparam int WIDTH = 32;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;
    localparam logic [2:0] OP_RSVD  = 3'b110;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
    } res_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    muldiv_unit_if #(.WIDTH(WIDTH)) bus ();

    muldiv_unit #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic straight from the instruction definitions.
    function automatic res_t model_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        res_t        r;
        longint      sx, sy, q, m;
        logic [63:0] p, uq, um;
        r  = '0;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        case (o)
            OP_MULT: begin
                p = sx * sy;
                r.hi = p[63:32]; r.lo = p[31:0];
            end
            OP_MULTU: begin
                p = {32'b0, x} * {32'b0, y};
                r.hi = p[63:32]; r.lo = p[31:0];
            end
            OP_DIV: begin
                if (y == 32'd0) begin
                    r.hi = x; r.lo = '1; r.dbz = 1'b1;
                end else begin
                    q = sx / sy; m = sx % sy;
                    r.lo = q[31:0]; r.hi = m[31:0];
                end
            end
            OP_DIVU: begin
                if (y == 32'd0) begin
                    r.hi = x; r.lo = '1; r.dbz = 1'b1;
                end else begin
                    uq = {32'b0, x} / {32'b0, y}; um = {32'b0, x} % {32'b0, y};
                    r.lo = uq[31:0]; r.hi = um[31:0];
                end
            end
            default: r = '0;
        endcase
        return r;
    endfunction

    function automatic int lat_of(input logic [2:0] o);
`ifdef MULDIV_FAST_MUL_EN
        if (o[2:1] == 2'b00) return 1;
`endif
        return WIDTH + 1;
    endfunction

    // Model state: visible HI/LO plus one outstanding op with edges remaining.
    logic        m_busy = 1'b0, m_done = 1'b0, m_dbz = 1'b0;
    logic [31:0] m_hi = '0, m_lo = '0;
    int          m_left = 0;
    res_t        m_res = '0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_busy <= 1'b0; m_done <= 1'b0; m_dbz <= 1'b0;
            m_hi <= '0; m_lo <= '0; m_left <= 0;
        end else begin
            m_done <= 1'b0;
            if (m_busy) begin
                if (bus.flush) begin
                    m_busy <= 1'b0;
                end else if (m_left == 1) begin
                    m_busy <= 1'b0;
                    m_hi <= m_res.hi; m_lo <= m_res.lo; m_dbz <= m_res.dbz;
                    m_done <= 1'b1;
                end else begin
                    m_left <= m_left - 1;
                end
            end else if (bus.start && !bus.flush) begin
                if (bus.op == OP_MTHI) begin
                    m_hi <= bus.a; m_done <= 1'b1; m_dbz <= 1'b0;
                end else if (bus.op == OP_MTLO) begin
                    m_lo <= bus.a; m_done <= 1'b1; m_dbz <= 1'b0;
                end else if (bus.op[2] == 1'b0) begin
                    m_busy <= 1'b1;
                    m_left <= lat_of(bus.op);
                    m_res  <= model_op(bus.op, bus.a, bus.b);
                end
            end
        end
    end

    // Every-cycle comparison on the falling edge.
    always @(negedge clk) begin
        check("busy", 64'(bus.busy), 64'(m_busy));
        check("done", 64'(bus.done), 64'(m_done));
        check("hi",   64'(bus.hi),   64'(m_hi));
        check("lo",   64'(bus.lo),   64'(m_lo));
        if (m_done) check("dbz", 64'(bus.dbz), 64'(m_dbz));
    end

    // Drive a request for one edge; returns 1ns after the start edge.
    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        bus.start = 1'b1; bus.op = o; bus.a = x; bus.b = y;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    // Wait (bounded) for done; reports edges after the start edge and busy cycles.
    task automatic wait_done(output int edges, output int busy_cyc);
        edges = 0;
        busy_cyc = bus.busy ? 1 : 0;
        while (!bus.done && edges < 100) begin
            @(posedge clk); #1;
            edges++;
            if (bus.busy) busy_cyc++;
        end
        if (!bus.done) check("done_timeout", 64'(bus.done), 64'd1);
    endtask

    task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] ehi, input logic [31:0] elo,
                          input logic edbz);
        int e, bc;
        issue(o, x, y);
        wait_done(e, bc);
        check({name, "_lat"}, 64'(e), 64'(lat_of(o)));
        check({name, "_hi"},  64'(bus.hi),  64'(ehi));
        check({name, "_lo"},  64'(bus.lo),  64'(elo));
        check({name, "_dbz"}, 64'(bus.dbz), 64'(edbz));
    endtask

    initial begin
        int e, bc, ndone;
        bus.start = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0; bus.flush = 1'b0;
        #1 reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_hi",   64'(bus.hi),   64'd0);
        check("rst_lo",   64'(bus.lo),   64'd0);
        reset = 1'b1;
        @(posedge clk); #1;

        // MULT -3 * 5 with latency and busy-length checks.
        issue(OP_MULT, 32'hFFFFFFFD, 32'd5);
        wait_done(e, bc);
        check("mult_lat",  64'(e),  64'(lat_of(OP_MULT)));
        check("mult_busy", 64'(bc), 64'(lat_of(OP_MULT)));
        check("mult_hi", 64'(bus.hi), 64'hFFFFFFFF);
        check("mult_lo", 64'(bus.lo), 64'hFFFFFFF1);
        @(posedge clk); #1;
        check("mult_done_1cyc", 64'(bus.done), 64'd0);

        run_op("divu",  OP_DIVU, 32'd100,      32'd7,        32'h00000002, 32'h0000000E, 1'b0);
        run_op("div_n", OP_DIV,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
        run_op("dbz",   OP_DIV,  32'h0000007B, 32'd0,        32'h0000007B, 32'hFFFFFFFF, 1'b1);
        run_op("dbzu",  OP_DIVU, 32'h80000001, 32'd0,        32'h80000001, 32'hFFFFFFFF, 1'b1);
        run_op("ovf",   OP_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0);
        run_op("mneg",  OP_MULT, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0);

        // MTHI, then MULTU issued in the done cycle.
        issue(OP_MTHI, 32'hDEADBEEF, 32'd0);
        check("mthi_done", 64'(bus.done), 64'd1);
        check("mthi_hi",   64'(bus.hi),   64'hDEADBEEF);
        issue(OP_MULTU, 32'd3, 32'd4);
        check("b2b_busy", 64'(bus.busy), 64'd1);
        wait_done(e, bc);
        check("b2b_hi", 64'(bus.hi), 64'h00000000);
        check("b2b_lo", 64'(bus.lo), 64'h0000000C);

        // MTLO, then a MULTU flushed at cycle 10 with an ignored start while busy.
        issue(OP_MTLO, 32'hA5A5A5A5, 32'd0);
        check("mtlo_lo", 64'(bus.lo), 64'hA5A5A5A5);
        issue(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        repeat (4) begin @(posedge clk); #1; end
        issue(OP_MTHI, 32'h12345678, 32'd0);
        repeat (4) begin @(posedge clk); #1; end
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        check("flush_busy", 64'(bus.busy), 64'd0);
        ndone = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.done) ndone++;
        end
        check("flush_nodone", 64'(ndone), 64'd0);
        check("flush_hi", 64'(bus.hi), 64'h00000000);
        check("flush_lo", 64'(bus.lo), 64'hA5A5A5A5);

        // Reserved op: no busy, no done, no state change.
        issue(OP_RSVD, 32'h11111111, 32'h22222222);
        check("rsvd_busy", 64'(bus.busy), 64'd0);
        check("rsvd_done", 64'(bus.done), 64'd0);
        check("rsvd_lo",   64'(bus.lo),   64'hA5A5A5A5);

        run_op("div_p", OP_DIV, 32'd7, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0);

        // Asynchronous reset in the middle of a DIV.
        issue(OP_DIV, 32'd1000, 32'd3);
        repeat (10) begin @(posedge clk); #1; end
        reset = 1'b0;
        #1;
        check("rst_mid_busy", 64'(bus.busy), 64'd0);
        check("rst_mid_hi",   64'(bus.hi),   64'd0);
        check("rst_mid_lo",   64'(bus.lo),   64'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;

        run_op("mul67", OP_MULT, 32'd6, 32'd7, 32'h00000000, 32'h0000002A, 1'b0);

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
